trig_match_former: RTL and testbench
====================================

Name: trig_match_former

Overview:
- Consumes the 1-bit `match` level from the coincidence comparator and turns it into a clean, fixed-width trigger pulse for the readout.
- Applies rising-edge detection, a prescaler, a readout ack handshake and a programmable deadtime.
- Keeps saturating match, trigger and lost counters.
- Sits between the comparator and the DAQ trigger distribution.

Parameters:
- STRETCH, 4, trig_out high time in clk cycles (1..255)
- DEADTIME, 16, cycles blocked after ack before rearming (0..65535)
- CNT_W, 32, width of scaler counters

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- match  in  1  coincidence level from the comparator (already registered upstream)
- enable  in  1  1 = trigger formation armed; 0 = no new triggers (counters keep counting)
- prescale  in  8  accept 1 of every prescale+1 qualified edges (0 = every edge)
- ack  in  1  readout done; single-cycle or level, sampled in WAIT_ACK only
- trig_out  out  1  trigger pulse, exactly STRETCH cycles wide
- busy  out  1  high in every state except IDLE
- match_cnt  out  CNT_W  count of match rising edges, saturating
- trig_cnt  out  CNT_W  count of issued triggers, saturating
- lost_cnt  out  CNT_W  rising edges seen while busy or !enable, saturating

Behaviour:
- Reset values: trig_out=0, busy=0, all counters 0, prescale counter 0, FSM=IDLE, edge register 0.
- Edge detect: `edge` = match & ~match_d, where match_d is a 1-cycle registered copy. A level held high yields one edge.
- match_cnt increments on every edge, whatever the state or enable.
- FSM states:
  - IDLE: on edge & enable, if psc_cnt==prescale, clear psc_cnt and go to FIRE; else psc_cnt++ and stay.
  - FIRE: trig_out=1. A width counter runs STRETCH cycles, then go to WAIT_ACK.
  - WAIT_ACK: trig_out=0; wait for ack=1. An ack asserted during FIRE is ignored.
  - DEAD: count DEADTIME cycles, then go to IDLE. If DEADTIME=0, go WAIT_ACK->IDLE directly.
- Latency: edge in IDLE at cycle n (match high at n, low at n-1) -> trig_out high at cycles n+1..n+STRETCH, registered output.
- trig_cnt increments on the IDLE->FIRE transition.
- lost_cnt increments on an edge when state!=IDLE, or when enable=0.
  - Prescaled-away edges are NOT lost.
- enable deassert mid-cycle: the current FIRE/WAIT_ACK/DEAD sequence completes normally. psc_cnt holds.
- prescale change: takes effect at the next compare. If psc_cnt>prescale, the next accepted edge fires and clears psc_cnt.
- Saturation: counters stop at all-ones, no wrap.
- Reset mid-operation: everything returns to reset values immediately, trig_out drops asynchronously.
- Simultaneous edge and FSM return to IDLE in the same cycle: the edge counts as lost, since state!=IDLE in that cycle.

Optional Feature:
- TRIG_TIMESTAMP_EN defined: adds output trig_ts [31:0].
  - A free-running 32-bit timestamp counter (wraps, reset 0) is latched into trig_ts on IDLE->FIRE.
  - trig_ts holds until the next trigger; reset value 0.
- Not defined: trig_ts port absent, no timestamp counter.

Decomposition:
- Package trig_pkg: FSM state encoding (IDLE, FIRE, WAIT_ACK, DEAD), default constants for STRETCH/DEADTIME/CNT_W.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output cnt): instantiated three times for the scalers.

Test Plan:
- Reset, then one match pulse 1->0 with enable=1, prescale=0, STRETCH=4: trig_out high exactly 4 cycles starting 1 cycle after the edge. trig_cnt=1, match_cnt=1, busy high until ack+16 cycles.
- prescale=3, 8 isolated edges spaced 40 cycles, ack returned promptly: trig_cnt=2 (on edges 4 and 8), match_cnt=8, lost_cnt=0.
- Edge arriving during FIRE and another during DEAD: no extra trigger, lost_cnt=2, match_cnt=3.
- enable=0, 5 edges: trig_out stays 0, match_cnt=5, lost_cnt=5. Re-enable, then 1 edge -> trigger fires.
- Assert reset during FIRE (cycle 2 of 4): trig_out=0 immediately, busy=0, all counters 0. The next edge after release triggers normally.
- With CNT_W=4, apply 20 edges: match_cnt saturates at 15. With TRIG_TIMESTAMP_EN, trig_ts equals the timestamp at the FIRE entry cycle.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger former: FSM state encoding and
// default values for the top-level parameters.
package trig_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StWaitAck,
        StDead
    } state_e;

    localparam int unsigned STRETCH_DEF  = 4;
    localparam int unsigned DEADTIME_DEF = 16;
    localparam int unsigned CNT_W_DEF    = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the match/trigger/lost scalers.
// It holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count up on inc until all-ones, then hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/trig_match_former.sv
// Trigger former: turns the comparator match level into a fixed-width
// trigger pulse. It performs rising-edge detection, prescaling, an ack
// handshake with the readout and a deadtime, and keeps saturating
// match/trigger/lost scalers.
// Optional: define TRIG_TIMESTAMP_EN to add the trig_ts output, which
// latches a free-running 32-bit timestamp on every issued trigger.
module trig_match_former
    import trig_pkg::*;
#(
    parameter int unsigned STRETCH  = STRETCH_DEF,
    parameter int unsigned DEADTIME = DEADTIME_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match,
    input  logic             enable,
    input  logic [7:0]       prescale,
    input  logic             ack,
    output logic             trig_out,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [CNT_W-1:0] lost_cnt
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [31:0]      trig_ts
`endif
);

    // Counters are loaded with N-1 and run down to 0, giving N cycles.
    localparam logic [7:0]  WidthInit = 8'(STRETCH - 1);
    localparam logic [15:0] DeadInit  = 16'(DEADTIME - 1);

    state_e      state_q;
    logic        match_d_q;
    logic        match_edge;
    logic [7:0]  psc_q;
    logic [7:0]  width_q;
    logic [15:0] dead_q;
    logic        trig_out_q;
    logic        fire;
    logic        lost_inc;

    // One-cycle delayed copy of match for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_d_q <= 1'b0;
        end else begin
            match_d_q <= match;
        end
    end

    assign match_edge = match & ~match_d_q;

    // >= rather than == so a prescale lowered below the running count
    // still fires on the next accepted edge.
    assign fire     = match_edge & enable & (state_q == StIdle) & (psc_q >= prescale);
    assign lost_inc = match_edge & ((state_q != StIdle) | ~enable);

    // Trigger FSM with registered trig_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            psc_q      <= 8'd0;
            width_q    <= 8'd0;
            dead_q     <= 16'd0;
            trig_out_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (match_edge && enable) begin
                        if (psc_q >= prescale) begin
                            psc_q      <= 8'd0;
                            width_q    <= WidthInit;
                            trig_out_q <= 1'b1;
                            state_q    <= StFire;
                        end else begin
                            psc_q <= psc_q + 8'd1;
                        end
                    end
                end
                StFire: begin
                    // ack is deliberately not looked at while firing.
                    if (width_q == 8'd0) begin
                        trig_out_q <= 1'b0;
                        state_q    <= StWaitAck;
                    end else begin
                        width_q <= width_q - 8'd1;
                    end
                end
                StWaitAck: begin
                    if (ack) begin
                        if (DEADTIME == 0) begin
                            state_q <= StIdle;
                        end else begin
                            dead_q  <= DeadInit;
                            state_q <= StDead;
                        end
                    end
                end
                StDead: begin
                    if (dead_q == 16'd0) begin
                        state_q <= StIdle;
                    end else begin
                        dead_q <= dead_q - 16'd1;
                    end
                end
                default: begin
                    trig_out_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign trig_out = trig_out_q;
    assign busy     = (state_q != StIdle);

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (match_edge),
        .cnt  (match_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_trig_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (fire),
        .cnt  (trig_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_lost_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (lost_inc),
        .cnt  (lost_cnt)
    );

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] trig_ts_q;

    // Free-running wrapping timestamp, sampled on each IDLE->FIRE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q      <= 32'd0;
            trig_ts_q <= 32'd0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (fire) begin
                trig_ts_q <= ts_q;
            end
        end
    end

    assign trig_ts = trig_ts_q;
`endif

endmodule

// File: tb/tb_trig_match_former.sv
// Directed self-checking bench for trig_match_former (STRETCH=4,
// DEADTIME=16, CNT_W=32) plus a CNT_W=4 instance for saturation.
module tb_trig_match_former;

    logic        clk;
    logic        reset;
    logic        match;
    logic        enable;
    logic [7:0]  prescale;
    logic        ack;
    logic        trig_out;
    logic        busy;
    logic [31:0] match_cnt;
    logic [31:0] trig_cnt;
    logic [31:0] lost_cnt;

    logic        rst4;
    logic        m4;
    logic        en4;
    logic [7:0]  psc4;
    logic        ack4;
    logic        trig_out4;
    logic        busy4;
    logic [3:0]  match_cnt4;
    logic [3:0]  trig_cnt4;
    logic [3:0]  lost_cnt4;

    int checks   = 0;
    int failures = 0;
    int hi_cnt   = 0;

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] trig_ts;
    logic [31:0] trig_ts4;
    logic [31:0] tb_ts;
    logic [31:0] ts_exp;

    // Reference timestamp: counts posedges since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= 32'd0;
        else       tb_ts <= tb_ts + 32'd1;
    end
`endif

    trig_match_former #(
        .STRETCH (4),
        .DEADTIME(16),
        .CNT_W   (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .match    (match),
        .enable   (enable),
        .prescale (prescale),
        .ack      (ack),
        .trig_out (trig_out),
        .busy     (busy),
        .match_cnt(match_cnt),
        .trig_cnt (trig_cnt),
        .lost_cnt (lost_cnt)
`ifdef TRIG_TIMESTAMP_EN
        ,
        .trig_ts  (trig_ts)
`endif
    );

    trig_match_former #(
        .STRETCH (4),
        .DEADTIME(16),
        .CNT_W   (4)
    ) dut4 (
        .clk      (clk),
        .reset    (rst4),
        .match    (m4),
        .enable   (en4),
        .prescale (psc4),
        .ack      (ack4),
        .trig_out (trig_out4),
        .busy     (busy4),
        .match_cnt(match_cnt4),
        .trig_cnt (trig_cnt4),
        .lost_cnt (lost_cnt4)
`ifdef TRIG_TIMESTAMP_EN
        ,
        .trig_ts  (trig_ts4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (trig_out) hi_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        hi_cnt = 0;
    endtask

    initial begin
        reset    = 1'b1;
        match    = 1'b0;
        enable   = 1'b1;
        prescale = 8'd0;
        ack      = 1'b0;
        rst4     = 1'b1;
        m4       = 1'b0;
        en4      = 1'b1;
        psc4     = 8'd0;
        ack4     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_trig_out", {31'd0, trig_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_match_cnt", match_cnt, 32'd0);
        chk("rst_trig_cnt", trig_cnt, 32'd0);
        chk("rst_lost_cnt", lost_cnt, 32'd0);
        reset = 1'b0;
        rst4  = 1'b0;
        tick();
        hi_cnt = 0;

        // Single edge: pulse 1 cycle after edge, 4 wide; busy until ack+16
        match = 1'b1;
`ifdef TRIG_TIMESTAMP_EN
        ts_exp = tb_ts;
`endif
        tick();
        chk("t1_hi_c1", {31'd0, trig_out}, 32'd1);
        match = 1'b0;
        tick();
        chk("t1_hi_c2", {31'd0, trig_out}, 32'd1);
        tick();
        chk("t1_hi_c3", {31'd0, trig_out}, 32'd1);
        tick();
        chk("t1_hi_c4", {31'd0, trig_out}, 32'd1);
        tick();
        chk("t1_lo_c5", {31'd0, trig_out}, 32'd0);
        chk("t1_busy_wait", {31'd0, busy}, 32'd1);
`ifdef TRIG_TIMESTAMP_EN
        chk("t1_trig_ts", trig_ts, ts_exp);
`endif
        repeat (3) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (15) tick();
        chk("t1_busy_dead_end", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        chk("t1_trig_cnt", trig_cnt, 32'd1);
        chk("t1_match_cnt", match_cnt, 32'd1);
        chk("t1_lost_cnt", lost_cnt, 32'd0);
        chk("t1_hi_cycles", hi_cnt, 32'd4);

        // Prescale 3: 8 edges -> triggers on edges 4 and 8
        do_reset();
        prescale = 8'd3;
        for (int i = 0; i < 8; i++) begin
            match = 1'b1;
            tick();
            match = 1'b0;
            repeat (5) tick();
            ack = 1'b1;
            tick();
            ack = 1'b0;
            repeat (33) tick();
        end
        chk("t2_trig_cnt", trig_cnt, 32'd2);
        chk("t2_match_cnt", match_cnt, 32'd8);
        chk("t2_lost_cnt", lost_cnt, 32'd0);
        chk("t2_hi_cycles", hi_cnt, 32'd8);
        prescale = 8'd0;

        // Edges during FIRE and DEAD are lost; ack during FIRE is ignored
        do_reset();
        match = 1'b1;
        tick();
        match = 1'b0;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        match = 1'b1;
        tick();
        match = 1'b0;
        tick();
        chk("t3_hi_c4", {31'd0, trig_out}, 32'd1);
        tick();
        chk("t3_lo_c5", {31'd0, trig_out}, 32'd0);
        repeat (20) tick();
        chk("t3_fire_ack_ignored", {31'd0, busy}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        match = 1'b1;
        tick();
        match = 1'b0;
        repeat (20) tick();
        chk("t3_busy_idle", {31'd0, busy}, 32'd0);
        chk("t3_trig_cnt", trig_cnt, 32'd1);
        chk("t3_lost_cnt", lost_cnt, 32'd2);
        chk("t3_match_cnt", match_cnt, 32'd3);

        // Disabled: edges counted and lost, no trigger; re-enable fires
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            match = 1'b1;
            tick();
            match = 1'b0;
            tick();
        end
        chk("t4_no_pulse", hi_cnt, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_match_cnt", match_cnt, 32'd5);
        chk("t4_lost_cnt", lost_cnt, 32'd5);
        chk("t4_trig_cnt0", trig_cnt, 32'd0);
        enable = 1'b1;
        match  = 1'b1;
        tick();
        chk("t4_reen_fire", {31'd0, trig_out}, 32'd1);
        match = 1'b0;
        repeat (5) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (20) tick();
        chk("t4_trig_cnt1", trig_cnt, 32'd1);
        chk("t4_lost_final", lost_cnt, 32'd5);

        // Asynchronous reset in the middle of FIRE
        do_reset();
        match = 1'b1;
        tick();
        match = 1'b0;
        tick();
        chk("t5_fire_c2", {31'd0, trig_out}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_trig_out", {31'd0, trig_out}, 32'd0);
        chk("t5_async_busy", {31'd0, busy}, 32'd0);
        chk("t5_async_match_cnt", match_cnt, 32'd0);
        chk("t5_async_trig_cnt", trig_cnt, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        match = 1'b1;
`ifdef TRIG_TIMESTAMP_EN
        ts_exp = tb_ts;
`endif
        tick();
        match = 1'b0;
        chk("t5_refire", {31'd0, trig_out}, 32'd1);
        chk("t5_trig_cnt", trig_cnt, 32'd1);
        chk("t5_match_cnt", match_cnt, 32'd1);
`ifdef TRIG_TIMESTAMP_EN
        chk("t5_trig_ts", trig_ts, ts_exp);
`endif
        repeat (5) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (20) tick();

        // Saturation on the CNT_W=4 instance: 20 edges
        for (int i = 0; i < 20; i++) begin
            m4 = 1'b1;
            tick();
            m4 = 1'b0;
            tick();
        end
        chk("t6_match_sat", {28'd0, match_cnt4}, 32'd15);
        chk("t6_trig_cnt", {28'd0, trig_cnt4}, 32'd1);
        chk("t6_lost_sat", {28'd0, lost_cnt4}, 32'd15);
        chk("t6_busy", {31'd0, busy4}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
